// File: rtl/master_port.sv
// Per-master serial bus port: takes a parallel request, arbitrates for the bus,
// serialises select/address/write data and deserialises read data.
module master_port #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dev_valid,
  output logic                  dev_ready,
  input  logic                  dev_write,
  input  logic [4:0]            dev_sel,
  input  logic [ADDR_WIDTH-1:0] dev_addr,
  input  logic [DATA_WIDTH-1:0] dev_wdata,
  output logic                  dev_done,
  output logic                  dev_err,
  output logic [DATA_WIDTH-1:0] dev_rdata,
  output logic                  mode,
  output logic                  wr_bus,
  input  logic                  rd_bus,
  input  logic                  ack,
  output logic                  master_valid,
  input  logic                  slave_ready,
  output logic                  master_ready,
  input  logic                  slave_valid,
  output logic                  breq,
  input  logic                  bgrant,
  input  logic                  split
);
  localparam int SEL_WIDTH = 5;
  localparam int TX_WIDTH  = SEL_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  localparam int MAX_AD    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int MAX_ADT   = (MAX_AD > ACK_TIMEOUT) ? MAX_AD : ACK_TIMEOUT;
  localparam int CNT_MAX   = (MAX_ADT > SEL_WIDTH) ? MAX_ADT : SEL_WIDTH;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, REQ, SEL, WAIT_ACK, ADDR, WDATA, RDATA, SPLIT_WAIT, DONE
  } state_t;

  state_t              state, state_n, resume_state;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [TX_WIDTH-1:0] tx_sr;
  logic                write_q;
  logic                err_q, err_n;
  logic                tx_shift, rx_shift;

  // NOTE: every bus-facing output is decoded from state, so the async reset
  // forcing IDLE drops breq/master_valid in the same instant, without a clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    err_n    = err_q;
    tx_shift = 1'b0;
    rx_shift = 1'b0;
    case (state)
      IDLE: if (dev_valid) begin
        state_n = REQ;
        err_n   = 1'b0;
      end
      REQ: if (bgrant) begin
        state_n = SEL;
        cnt_n   = CNT_W'(SEL_WIDTH - 1);
      end
      SEL: begin
        if (!bgrant) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else if (slave_ready) begin
          tx_shift = 1'b1;
          if (cnt == '0) begin
            state_n = WAIT_ACK;
            cnt_n   = '0;
          end else cnt_n = cnt - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (!bgrant) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else if (ack) begin
          // ack is checked before the timeout so a last-moment ack still wins
          state_n = ADDR;
          cnt_n   = CNT_W'(ADDR_WIDTH - 1);
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      ADDR, WDATA: begin
        if (split) state_n = SPLIT_WAIT;
        else if (!bgrant) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else if (slave_ready) begin
          tx_shift = 1'b1;
          if (cnt == '0) begin
            if (state == ADDR) begin
              state_n = write_q ? WDATA : RDATA;
              cnt_n   = CNT_W'(DATA_WIDTH - 1);
            end else state_n = DONE;
          end else cnt_n = cnt - 1'b1;
        end
      end
      RDATA: begin
        if (split) state_n = SPLIT_WAIT;
        else if (!bgrant) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else if (slave_valid) begin
          rx_shift = 1'b1;
          if (cnt == '0) state_n = DONE;
          else           cnt_n   = cnt - 1'b1;
        end
      end
      SPLIT_WAIT: if (!split) state_n = resume_state;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // cnt and the shift register are left untouched in SPLIT_WAIT, which is
  // what preserves the bit position across a split.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= '0;
      err_q        <= 1'b0;
      write_q      <= 1'b0;
      tx_sr        <= '0;
      dev_rdata    <= '0;
      resume_state <= IDLE;
    end else begin
      cnt   <= cnt_n;
      err_q <= err_n;
      if (state == IDLE && dev_valid) begin
        write_q <= dev_write;
        tx_sr   <= {dev_sel, dev_addr, dev_wdata};
      end else if (tx_shift) begin
        tx_sr <= {tx_sr[TX_WIDTH-2:0], 1'b0};
      end
      if (rx_shift) dev_rdata <= {dev_rdata[DATA_WIDTH-2:0], rd_bus};
      if (state_n == SPLIT_WAIT && state != SPLIT_WAIT) resume_state <= state;
    end
  end

  assign dev_ready    = (state == IDLE);
  assign dev_done     = (state == DONE);
  assign dev_err      = dev_done & err_q;
  assign mode         = write_q;
  assign breq         = state inside {REQ, SEL, WAIT_ACK, ADDR, WDATA, RDATA, SPLIT_WAIT};
  assign master_valid = state inside {SEL, ADDR, WDATA};
  assign master_ready = (state == RDATA);
  assign wr_bus       = master_valid & tx_sr[TX_WIDTH-1];

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: a small cycle-by-cycle slave/arbiter model
// drives the bus and records what the port sends and returns.
`timescale 1ns/1ps
module tb_master_port;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dev_valid, dev_ready, dev_write, dev_done, dev_err;
  logic [4:0]  dev_sel;
  logic [11:0] dev_addr;
  logic [7:0]  dev_wdata, dev_rdata;
  logic        mode, wr_bus, rd_bus, ack, master_valid, slave_ready;
  logic        master_ready, slave_valid, breq, bgrant, split;

  int checks = 0;
  int errors = 0;

  logic [63:0] r_stream;
  int          r_nbits, r_rbits, r_done_cyc, r_drop_cyc;
  logic        r_err, r_done_breq;
  logic [7:0]  r_rdata;
  bit          r_mode_bad, r_ready_bad, r_split_bad, r_aborted;

  master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_write(dev_write),
    .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_done(dev_done), .dev_err(dev_err), .dev_rdata(dev_rdata),
    .mode(mode), .wr_bus(wr_bus), .rd_bus(rd_bus), .ack(ack),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .master_ready(master_ready), .slave_valid(slave_valid),
    .breq(breq), .bgrant(bgrant), .split(split)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction, accepted at cycle 0. Negative knobs disable a feature.
  task automatic run_txn(input logic wr, input logic [4:0] sel, input logic [11:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd, input int ack_wait,
                         input bit toggle, input int split_after, input int split_len,
                         input int drop_bit, input int rst_bit);
    int  sel_end = -1;
    int  split_left = 0;
    bit  split_done = 1'b0;
    r_stream = '0; r_nbits = 0; r_rbits = 0; r_done_cyc = -1; r_drop_cyc = -1;
    r_err = 1'bx; r_done_breq = 1'bx; r_rdata = 'x;
    r_mode_bad = 0; r_ready_bad = 0; r_split_bad = 0; r_aborted = 0;
    dev_valid = 1'b1; dev_write = wr; dev_sel = sel; dev_addr = addr; dev_wdata = wd;
    bgrant = 1'b1; slave_ready = 1'b1; ack = 1'b0; split = 1'b0;
    slave_valid = 1'b0; rd_bus = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin
        // keep requesting with scrambled fields: the port must use its latched copy
        dev_write = ~wr; dev_sel = ~sel; dev_addr = ~addr; dev_wdata = ~wd;
        if (mode !== wr) r_mode_bad = 1;
        if (dev_done === 1'b1) begin
          r_done_cyc = c; r_err = dev_err; r_rdata = dev_rdata; r_done_breq = breq;
          dev_valid = 1'b0;
          @(posedge clk); #1;
          return;
        end
        if (dev_ready !== 1'b0) r_ready_bad = 1;
      end
      if (rst_bit >= 0 && master_valid && r_nbits == rst_bit) begin
        rstn = 1'b0; #1;
        check("rst_breq", breq, 0);
        check("rst_master_valid", master_valid, 0);
        dev_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1; #1;
        r_aborted = 1;
        return;
      end
      ack = (sel_end >= 0) && (c >= sel_end + 1 + ack_wait);
      if (split_left > 0) begin
        if (breq !== 1'b1 || master_ready !== 1'b0) r_split_bad = 1;
        split = 1'b1; bgrant = 1'b0; split_left--;
      end else if (!split_done && split_after >= 0 && master_ready && r_rbits == split_after) begin
        split_done = 1'b1; split = 1'b1; bgrant = 1'b0; split_left = split_len - 1;
      end else begin
        split = 1'b0; bgrant = 1'b1;
      end
      if (drop_bit >= 0 && master_valid && r_nbits == 5 + drop_bit) begin
        bgrant = 1'b0; r_drop_cyc = c;
      end
      slave_valid = split ? 1'b0 : (toggle ? c[0] : 1'b1);
      rd_bus = (r_rbits < 8) ? rd[7 - r_rbits] : 1'b0;
      if (master_valid && slave_ready && bgrant && !split) begin
        r_stream = {r_stream[62:0], wr_bus};
        r_nbits++;
        if (r_nbits == 5) sel_end = c;
      end
      if (master_ready && slave_valid && bgrant && !split) r_rbits++;
      @(posedge clk); #1;
    end
    dev_valid = 1'b0;
  endtask

  initial begin
    dev_valid = 0; dev_write = 0; dev_sel = '0; dev_addr = '0; dev_wdata = '0;
    rd_bus = 0; ack = 0; slave_ready = 0; slave_valid = 0; bgrant = 0; split = 0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;

    check("reset_dev_ready", dev_ready, 1);
    check("reset_breq", breq, 0);
    check("reset_master_valid", master_valid, 0);
    check("reset_master_ready", master_ready, 0);
    check("reset_wr_bus", wr_bus, 0);
    check("reset_mode", mode, 0);
    check("reset_done_err", {dev_done, dev_err}, 0);
    check("reset_rdata", dev_rdata, 0);

    // best-case write
    run_txn(1'b1, 5'b00010, 12'h0A5, 8'h3C, 8'h00, 0, 1'b0, -1, 0, -1, -1);
    check("wr_done_cycle", r_done_cyc, 28);
    check("wr_err", r_err, 0);
    check("wr_nbits", r_nbits, 25);
    check("wr_stream", r_stream[24:0], {5'b00010, 12'h0A5, 8'h3C});
    check("wr_mode_held", r_mode_bad, 0);
    check("wr_busy_not_ready", r_ready_bad, 0);
    check("wr_done_breq", r_done_breq, 0);
    check("wr_ready_after_done", dev_ready, 1);

    // read with slave_valid toggling
    run_txn(1'b0, 5'b00100, 12'h3F0, 8'hFF, 8'hC3, 0, 1'b1, -1, 0, -1, -1);
    check("rd_err", r_err, 0);
    check("rd_rdata", r_rdata, 8'hC3);
    check("rd_rbits", r_rbits, 8);
    check("rd_header", r_stream[16:0], {5'b00100, 12'h3F0});
    check("rd_nbits", r_nbits, 17);
    check("rd_mode_held", r_mode_bad, 0);
    check("rd_rdata_held", dev_rdata, 8'hC3);

    // best-case read
    run_txn(1'b0, 5'b10001, 12'h801, 8'h00, 8'hA5, 0, 1'b0, -1, 0, -1, -1);
    check("rdb_done_cycle", r_done_cyc, 28);
    check("rdb_rdata", r_rdata, 8'hA5);

    // no ack: timeout after 16 waiting cycles
    run_txn(1'b1, 5'b00110, 12'h123, 8'h45, 8'h00, 1000, 1'b0, -1, 0, -1, -1);
    check("to_done_cycle", r_done_cyc, 23);
    check("to_err", r_err, 1);
    check("to_no_addr", r_nbits, 5);
    check("to_done_breq", r_done_breq, 0);

    // ack on the final timeout cycle wins
    run_txn(1'b1, 5'b01001, 12'hABC, 8'h96, 8'h00, 15, 1'b0, -1, 0, -1, -1);
    check("ackedge_done_cycle", r_done_cyc, 43);
    check("ackedge_err", r_err, 0);
    check("ackedge_stream", r_stream[24:0], {5'b01001, 12'hABC, 8'h96});

    // split after 3 read bits, 20 cycles with bgrant low
    run_txn(1'b0, 5'b00100, 12'h055, 8'h00, 8'h5A, 0, 1'b0, 3, 20, -1, -1);
    check("split_done_cycle", r_done_cyc, 49);
    check("split_err", r_err, 0);
    check("split_rdata", r_rdata, 8'h5A);
    check("split_breq_held", r_split_bad, 0);
    check("split_rbits", r_rbits, 8);

    // grant lost after 6 address bits
    run_txn(1'b1, 5'b00010, 12'h0A5, 8'h3C, 8'h00, 0, 1'b0, -1, 0, 6, -1);
    check("gl_drop_cycle", r_drop_cyc, 14);
    check("gl_done_cycle", r_done_cyc, r_drop_cyc + 1);
    check("gl_err", r_err, 1);

    // reset during write data, then a clean write
    run_txn(1'b1, 5'b00010, 12'h0A5, 8'h3C, 8'h00, 0, 1'b0, -1, 0, -1, 20);
    check("rst_aborted", r_aborted, 1);
    check("rst_ready_after", dev_ready, 1);
    check("rst_idle_outputs", {breq, master_valid, dev_done, mode}, 0);
    run_txn(1'b1, 5'b11111, 12'hFFF, 8'h81, 8'h00, 0, 1'b0, -1, 0, -1, -1);
    check("post_rst_done_cycle", r_done_cyc, 28);
    check("post_rst_err", r_err, 0);
    check("post_rst_stream", r_stream[24:0], {5'b11111, 12'hFFF, 8'h81});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
